// File: rtl/pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// pipelined_adder_nbit
//
// Pipelined WIDTH-bit adder/subtractor. The operands are split into STAGE_BITS
// wide chunks. Each pipeline stage ripples one chunk and registers the result,
// and the chunk's carry-out feeds the next stage on the following cycle. Every
// stage register carries the finished low chunks and the raw high chunks, so a
// result leaves the last stage complete. Latency is STAGES cycles and
// throughput is one result per cycle. One global stall signal freezes the
// whole pipe while the output is held.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand set presented
//   in_ready   operands accepted this cycle (combinational from out_ready)
//   a, b       WIDTH-bit operands
//   c_in       carry-in for add; ignored when sub = 1
//   sub        0: a + b + c_in, 1: a - b (a + ~b + 1)
//   out_valid  result present
//   out_ready  downstream accepts the result
//   sum        WIDTH+1 bit result; sum[WIDTH] is carry-out (sub: 1 = no borrow)
//   overflow   signed overflow of the WIDTH-bit result
// -----------------------------------------------------------------------------
module pipelined_adder_nbit #(
  parameter int WIDTH      = 26,
  parameter int STAGE_BITS = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  // The last chunk may be narrower than STAGE_BITS.
  localparam int STAGES = (WIDTH + STAGE_BITS - 1) / STAGE_BITS;

  // Stage registers. Stage k holds the sum bits of chunks 0..k, the carry out
  // of chunk k and the operand bits still to be added by later stages.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic             c_q     [STAGES];
  logic             ovf_q;

  // Stage inputs: the ports for stage 0, the previous stage register otherwise.
  logic             st_v [STAGES];
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];

  // Stage results, loaded into the stage registers on advance.
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];
  logic             ovf_nx;

  logic             advance;

  // One stall signal for the whole pipe: it moves only when the output slot is
  // empty or is being taken this cycle.
  assign out_valid = valid_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  assign sum      = {c_q[STAGES-1], s_q[STAGES-1]};
  assign overflow = ovf_q;

  // Subtraction is folded in here as ~b with a forced carry-in of 1, so the
  // stages only ever add and sub is not carried down the pipe.
  always_comb begin
    st_v[0] = in_valid;
    st_a[0] = a;
    st_b[0] = sub ? ~b : b;
    st_s[0] = '0;
    st_c[0] = sub | c_in;
    for (int k = 1; k < STAGES; k++) begin
      st_v[k] = valid_q[k-1];
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
    end
  end

  // Per-stage ripple over that stage's chunk only. The bits of other chunks
  // pass through unchanged.
  always_comb begin : ripple
    logic carry;
    logic carry_msb;
    // NOTE: every output of this block is given a default before the loops, so
    // no path leaves a value unassigned and no latch is inferred.
    ovf_nx = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      nx_s[k]   = st_s[k];
      carry     = st_c[k];
      carry_msb = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (i / STAGE_BITS == k) begin
          if (i == WIDTH - 1) carry_msb = carry;
          nx_s[k][i] = st_a[k][i] ^ st_b[k][i] ^ carry;
          // NOTE: carry is a blocking temporary. Each iteration must see the
          // carry produced by the bit below it in the same evaluation.
          carry = (st_a[k][i] & st_b[k][i]) | (carry & (st_a[k][i] ^ st_b[k][i]));
        end
      end
      nx_c[k] = carry;
      // Only the last stage contains bit WIDTH-1, so only it has a meaningful
      // carry into and out of the MSB.
      if (k == STAGES - 1) ovf_nx = carry_msb ^ carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are cleared as well as the valid bits, so sum
      // and overflow read as 0 straight after reset.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      // Bubbles move through as valid = 0. They are not squeezed out.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= st_v[k];
        a_q[k]     <= st_a[k];
        b_q[k]     <= st_b[k];
        s_q[k]     <= nx_s[k];
        c_q[k]     <= nx_c[k];
      end
      ovf_q <= ovf_nx;
    end
  end

endmodule

// File: doc/pipelined_adder_nbit.md
Name: pipelined_adder_nbit

Overview:
- Parametrised, pipelined successor to the 13-bit ripple-carry adder.
- Splits a WIDTH-bit add or subtract into STAGE_BITS-wide ripple chunks, with one register stage per chunk and the carry passed between stages.
- Valid/ready handshakes on both sides give one result per cycle at full throughput.
- Used as the wide adder (26 bits and up) in the datapath experiments, where a single ripple chain misses timing.

Parameters:
- WIDTH, 26, operand width in bits (>=1).
- STAGE_BITS, 13, bits resolved per pipeline stage (1..WIDTH).
- STAGES, ceil(WIDTH/STAGE_BITS), derived (localparam); the last chunk may be narrower.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+c_in; 1: A-B (A + ~B + 1).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH+1  result; bit WIDTH is carry-out (in sub mode, 1 = no borrow, i.e. A>=B unsigned).
- overflow  output  1  signed overflow of the WIDTH-bit result: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync-safe deassert is the integrator's job):
  - all stage valid bits = 0, all stage data registers = 0.
  - out_valid = 0, sum = 0, overflow = 0.
  - Reset mid-operation discards all in-flight results; nothing emerges afterwards.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready; no register on that path).
  - When advance=0, every stage register, including its valid bit, holds its value. sum and overflow stay stable while out_valid && !out_ready.
- Pipeline:
  - Stage k (0..STAGES-1) adds chunk k of A and B' (B' = sub ? ~b : b) plus the carry from stage k-1.
  - Stage 0 uses carry cin0 = sub ? 1 : c_in.
  - Each stage registers: its sum chunk, its carry-out, and the not-yet-processed upper chunks of A and B'.
  - Lower finished chunks shift along with the data.
  - sub is folded into B' and cin0 at the input, so it is not carried further.
- Latency: exactly STAGES cycles from input transfer to out_valid when unstalled (2 for the defaults).
- Throughput: one result per cycle. A bubble (in_valid=0 while advancing) propagates as valid=0; bubbles are not collapsed.
- Width rules:
  - The last chunk width is WIDTH - (STAGES-1)*STAGE_BITS.
  - sum[WIDTH] is the carry-out of the final stage.
  - overflow uses the carry into bit WIDTH-1 from the last stage's ripple.
- Edge cases:
  - STAGE_BITS >= WIDTH gives STAGES=1, i.e. a single registered adder.
  - STAGE_BITS=1 gives a bit-serial pipeline of depth WIDTH.
- Ordering: results exit in input order; none are dropped or duplicated under any out_ready pattern.
- Simultaneous events: input accept and output accept in the same cycle are legal (steady state).

Test Plan (WIDTH=26, STAGE_BITS=13 unless noted):
- Reset/idle:
  - Stimulus: hold rst=1, then release with in_valid=0.
  - Required: out_valid=0, sum=0, overflow=0, in_ready=1.
- Chunk-boundary carry:
  - Stimulus: a=0x0001FFF, b=0x0000001, c_in=0, sub=0, out_ready=1.
  - Required: after exactly 2 cycles, out_valid=1 and sum=0x0002000; the carry crosses bit 12→13.
- Full-width wrap and signed overflow:
  - Stimulus 1: a=0x3FFFFFF, b=0x0000001, c_in=0.
  - Required 1: sum=0x4000000 (carry-out 1), overflow=0.
  - Stimulus 2: a=0x1FFFFFF, b=1.
  - Required 2: sum=0x2000000, overflow=1.
- Subtract:
  - Stimulus 1: sub=1, a=5, b=7.
  - Required 1: sum[25:0]=0x3FFFFFE, sum[26]=0 (borrow).
  - Stimulus 2: sub=1, a=7, b=5; c_in=1 must be ignored.
  - Required 2: sum=0x4000002.
- Backpressure and streaming:
  - Stimulus: 8 back-to-back random operand sets; hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 while stalled; sum stable while held; all 8 results match the reference model, in order, with none lost.
- Reset mid-stream and parameter corners:
  - Stimulus: assert rst with 2 operand sets in flight.
  - Required: out_valid drops immediately and no stale result appears afterwards.
  - Rerun the random stream with (WIDTH=26, STAGE_BITS=26) → latency 1, and (WIDTH=8, STAGE_BITS=3) → latency 3, last chunk 2 bits.
